// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: single-outstanding imem requester feeding a small
// {pc,instr} prefetch FIFO, with redirect flush and in-flight drop handling.
module instr_fetch_unit #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [63:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [63:0] out_pc
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

  state_t           state;
  logic             req_q;
  logic [63:0]      req_addr;
  logic [63:0]      fetch_pc;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  logic [63:0] pc_mem    [DEPTH];
  logic [31:0] instr_mem [DEPTH];

  logic [63:0]      redir_pc;
  logic [63:0]      next_pc;
  logic             push;
  logic             pop;
  logic [CNT_W-1:0] count_after;

  function automatic logic [63:0] align_pc(input logic [63:0] pc);
    return {pc[63:2], 2'b00};
  endfunction

  // Pointers wrap modulo DEPTH, which need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign redir_pc    = align_pc(redirect_pc);
  assign next_pc     = fetch_pc + 64'd4;
  assign push        = (state == REQ) && imem_ack && !redirect;
  assign pop         = (count != '0) && out_ready && !redirect;
  assign count_after = count + CNT_W'(push) - CNT_W'(pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      req_q    <= 1'b0;
      req_addr <= RESET_PC;
      fetch_pc <= RESET_PC;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      if (redirect) begin
        count    <= '0;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        fetch_pc <= redir_pc;
      end else begin
        count <= count_after;
        if (push) begin
          wr_ptr   <= ptr_inc(wr_ptr);
          fetch_pc <= next_pc;
        end
        if (pop) rd_ptr <= ptr_inc(rd_ptr);
      end

      // req_addr only moves when a new request is launched, so the address of
      // an abandoned request stays on the bus while DROP waits for its ack.
      case (state)
        IDLE: begin
          if (redirect) begin
            state    <= REQ;
            req_q    <= 1'b1;
            req_addr <= redir_pc;
          end else if (count < DEPTH_C) begin
            state    <= REQ;
            req_q    <= 1'b1;
            req_addr <= fetch_pc;
          end
        end
        REQ: begin
          if (redirect) begin
            if (imem_ack) req_addr <= redir_pc;
            else          state    <= DROP;
          end else if (imem_ack) begin
            if (count_after < DEPTH_C) begin
              req_addr <= next_pc;
            end else begin
              state <= IDLE;
              req_q <= 1'b0;
            end
          end
        end
        DROP: begin
          if (imem_ack) begin
            state    <= REQ;
            req_addr <= redirect ? redir_pc : fetch_pc;
          end
        end
        default: begin
          state <= IDLE;
          req_q <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]    <= fetch_pc;
      instr_mem[wr_ptr] <= imem_rdata;
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = req_addr;
  assign out_valid = (count != '0);
  assign out_instr = instr_mem[rd_ptr];
  assign out_pc    = pc_mem[rd_ptr];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit (RESET_PC=0, DEPTH=2).
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [63:0] out_pc;

  int checks = 0;
  int errors = 0;
  bit auto_ack = 1'b0;

  always #5 clk = ~clk;

  instr_fetch_unit #(.RESET_PC(64'h0), .DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc)
  );

  function automatic logic [31:0] rd(input logic [63:0] a);
    return a[31:0] ^ 32'h1357_0000;
  endfunction

  // Zero-wait memory model: ack whatever is being requested this cycle.
  task automatic respond();
    if (auto_ack) begin
      imem_ack   = imem_req;
      imem_rdata = rd(imem_addr);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    respond();
  endtask

  task automatic do_reset();
    rst = 1'b1; redirect = 1'b0; redirect_pc = '0;
    imem_ack = 1'b0; imem_rdata = '0; out_ready = 1'b0; auto_ack = 1'b0;
    cycle(); cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; redirect = 1'b1; redirect_pc = 64'h400;
    imem_ack = 1'b1; imem_rdata = 32'hBAD0_0000; out_ready = 1'b1; auto_ack = 1'b0;
    cycle(); cycle();
    checks++;
    if (imem_req !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: imem_req=%b out_valid=%b, expected 0 0", imem_req, out_valid);
    end
    rst = 1'b0; redirect = 1'b0; imem_ack = 1'b0;
    cycle();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 64'h0) begin
      errors++;
      $display("FAIL reset_first_req: imem_req=%b addr=%h, expected 1 0", imem_req, imem_addr);
    end
  endtask

  task automatic test_streaming();
    logic [63:0] exp = 64'h0;
    int got = 0;
    bit started = 1'b0;
    do_reset();
    out_ready = 1'b1; auto_ack = 1'b1; respond();
    for (int i = 0; i < 20 && got < 12; i++) begin
      if (out_valid) begin
        started = 1'b1;
        checks++;
        if (out_pc !== exp || out_instr !== rd(exp)) begin
          errors++;
          $display("FAIL stream_data: pc=%h instr=%h, expected pc=%h instr=%h", out_pc, out_instr, exp, rd(exp));
        end
        exp += 64'd4;
        got++;
      end else if (started) begin
        checks++; errors++;
        $display("FAIL stream_bubble: out_valid=0 at iteration %0d, expected 1", i);
      end
      cycle();
    end
    checks++;
    if (got != 12) begin
      errors++;
      $display("FAIL stream_count: got %0d instructions, expected 12", got);
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] exp = 64'h0;
    int got = 0;
    bit seen_req = 1'b0;
    do_reset();
    out_ready = 1'b0; auto_ack = 1'b1; respond();
    for (int i = 0; i < 4; i++) cycle();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (imem_req !== 1'b0 || out_valid !== 1'b1 || out_pc !== 64'h0) begin
        errors++;
        $display("FAIL bp_stall: imem_req=%b out_valid=%b pc=%h, expected 0 1 0", imem_req, out_valid, out_pc);
      end
      cycle();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 12 && got < 4; i++) begin
      if (imem_req && !seen_req) begin
        seen_req = 1'b1;
        checks++;
        if (imem_addr !== 64'h8) begin
          errors++;
          $display("FAIL bp_resume_addr: addr=%h, expected 8", imem_addr);
        end
      end
      if (out_valid) begin
        checks++;
        if (out_pc !== exp || out_instr !== rd(exp)) begin
          errors++;
          $display("FAIL bp_order: pc=%h instr=%h, expected pc=%h instr=%h", out_pc, out_instr, exp, rd(exp));
        end
        exp += 64'd4;
        got++;
      end
      cycle();
    end
    checks++;
    if (got != 4 || !seen_req) begin
      errors++;
      $display("FAIL bp_drain: got %0d outputs seen_req=%b, expected 4 1", got, seen_req);
    end
  endtask

  task automatic test_redirect_wait();
    logic [63:0] exp = 64'h200;
    int got = 0;
    do_reset();
    out_ready = 1'b1;
    cycle();
    // Redirect with a same-cycle ack to put a request to 0x10 on the bus.
    imem_ack = 1'b1; imem_rdata = 32'hBAD0_0000; redirect = 1'b1; redirect_pc = 64'h10;
    cycle();
    imem_ack = 1'b0; redirect = 1'b0;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 64'h10 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rw_setup: req=%b addr=%h valid=%b, expected 1 10 0", imem_req, imem_addr, out_valid);
    end
    redirect = 1'b1; redirect_pc = 64'h200;
    cycle();
    redirect = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 64'h10) begin
        errors++;
        $display("FAIL rw_hold: req=%b addr=%h, expected 1 10", imem_req, imem_addr);
      end
      if (i == 0) cycle();
    end
    imem_ack = 1'b1; imem_rdata = 32'hBAD0_0010;
    cycle();
    imem_ack = 1'b0;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 64'h200 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rw_new_addr: req=%b addr=%h valid=%b, expected 1 200 0", imem_req, imem_addr, out_valid);
    end
    auto_ack = 1'b1; respond();
    for (int i = 0; i < 10 && got < 3; i++) begin
      if (out_valid) begin
        checks++;
        if (out_pc !== exp || out_instr !== rd(exp)) begin
          errors++;
          $display("FAIL rw_stream: pc=%h instr=%h, expected pc=%h instr=%h", out_pc, out_instr, exp, rd(exp));
        end
        exp += 64'd4;
        got++;
      end
      cycle();
    end
    checks++;
    if (got != 3) begin
      errors++;
      $display("FAIL rw_count: got %0d outputs, expected 3", got);
    end
  endtask

  task automatic test_redirect_ack_pop();
    logic [63:0] exp = 64'h200;
    int got = 0;
    do_reset();
    out_ready = 1'b1; auto_ack = 1'b1; respond();
    for (int i = 0; i < 4; i++) cycle();
    checks++;
    if (out_valid !== 1'b1 || imem_req !== 1'b1 || imem_ack !== 1'b1) begin
      errors++;
      $display("FAIL rap_setup: valid=%b req=%b ack=%b, expected 1 1 1", out_valid, imem_req, imem_ack);
    end
    redirect = 1'b1; redirect_pc = 64'h203;
    cycle();
    redirect = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 64'h200) begin
      errors++;
      $display("FAIL rap_flush: valid=%b req=%b addr=%h, expected 0 1 200", out_valid, imem_req, imem_addr);
    end
    for (int i = 0; i < 8 && got < 2; i++) begin
      if (out_valid) begin
        checks++;
        if (out_pc !== exp || out_instr !== rd(exp)) begin
          errors++;
          $display("FAIL rap_stream: pc=%h instr=%h, expected pc=%h instr=%h", out_pc, out_instr, exp, rd(exp));
        end
        exp += 64'd4;
        got++;
      end
      cycle();
    end
    checks++;
    if (got != 2) begin
      errors++;
      $display("FAIL rap_count: got %0d outputs, expected 2", got);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    out_ready = 1'b1;
    cycle();
    redirect = 1'b1; redirect_pc = 64'h300;
    cycle();
    redirect_pc = 64'h400;
    cycle();
    redirect_pc = 64'h501; imem_ack = 1'b1; imem_rdata = 32'hBAD0_0000;
    cycle();
    redirect = 1'b0; imem_ack = 1'b0;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 64'h500 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_last_wins: req=%b addr=%h valid=%b, expected 1 500 0", imem_req, imem_addr, out_valid);
    end
    auto_ack = 1'b1; respond();
    cycle();
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 64'h500 || out_instr !== rd(64'h500)) begin
      errors++;
      $display("FAIL b2b_first_out: valid=%b pc=%h instr=%h, expected 1 500 %h", out_valid, out_pc, out_instr, rd(64'h500));
    end
  endtask

  task automatic test_wrap();
    logic [63:0] exp = 64'hFFFF_FFFF_FFFF_FFFC;
    int got = 0;
    do_reset();
    out_ready = 1'b1; auto_ack = 1'b1;
    redirect = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    cycle();
    redirect = 1'b0;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin
      errors++;
      $display("FAIL wrap_addr: req=%b addr=%h, expected 1 fffffffffffffffc", imem_req, imem_addr);
    end
    for (int i = 0; i < 8 && got < 3; i++) begin
      if (out_valid) begin
        checks++;
        if (out_pc !== exp || out_instr !== rd(exp)) begin
          errors++;
          $display("FAIL wrap_seq: pc=%h instr=%h, expected pc=%h instr=%h", out_pc, out_instr, exp, rd(exp));
        end
        exp += 64'd4;
        got++;
      end
      cycle();
    end
    checks++;
    if (got != 3) begin
      errors++;
      $display("FAIL wrap_count: got %0d outputs, expected 3", got);
    end
  endtask

  task automatic test_reset_mid_request();
    logic [63:0] exp = 64'h0;
    int got = 0;
    do_reset();
    out_ready = 1'b0; auto_ack = 1'b1; respond();
    cycle(); cycle();
    auto_ack = 1'b0; imem_ack = 1'b0;
    cycle();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 64'h4) begin
      errors++;
      $display("FAIL rmr_pending: req=%b addr=%h, expected 1 4", imem_req, imem_addr);
    end
    rst = 1'b1;
    cycle();
    imem_ack = 1'b1; imem_rdata = 32'hBAD0_0004;
    cycle();
    checks++;
    if (imem_req !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rmr_reset: req=%b valid=%b, expected 0 0", imem_req, out_valid);
    end
    rst = 1'b0;
    cycle();
    imem_ack = 1'b0;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 64'h0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rmr_restart: req=%b addr=%h valid=%b, expected 1 0 0", imem_req, imem_addr, out_valid);
    end
    out_ready = 1'b1; auto_ack = 1'b1; respond();
    for (int i = 0; i < 8 && got < 2; i++) begin
      if (out_valid) begin
        checks++;
        if (out_pc !== exp || out_instr !== rd(exp)) begin
          errors++;
          $display("FAIL rmr_stream: pc=%h instr=%h, expected pc=%h instr=%h", out_pc, out_instr, exp, rd(exp));
        end
        exp += 64'd4;
        got++;
      end
      cycle();
    end
    checks++;
    if (got != 2) begin
      errors++;
      $display("FAIL rmr_count: got %0d outputs, expected 2", got);
    end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_redirect_wait();
    test_redirect_ack_pop();
    test_back_to_back();
    test_wrap();
    test_reset_mid_request();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 64'h0: fetch address loaded on reset.
REQ-002 Parameter DEPTH, default 2: prefetch buffer entries; legal values 2..8.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 imem_req  output  1  instruction-memory request; held high until acknowledged.
REQ-006 imem_addr  output  64  fetch byte address; bits [1:0] always 0.
REQ-007 imem_ack  input  1  request accepted; imem_rdata valid this cycle.
REQ-008 imem_rdata  input  32  fetched instruction word.
REQ-009 redirect  input  1  branch-taken pulse from the execute stage; flushes the fetch stream.
REQ-010 redirect_pc  input  64  new fetch target; sampled when redirect=1.
REQ-011 out_valid  output  1  buffer head holds a valid instruction for decode.
REQ-012 out_ready  input  1  decode consumes the head this cycle.
REQ-013 out_instr  output  32  head instruction word.
REQ-014 out_pc  output  64  address of out_instr.

Function
REQ-015 The block SHALL hold a 64-bit fetch_pc, a DEPTH-entry FIFO of {pc,instr}, an entry count, and a 3-state FSM: IDLE, REQ, DROP.
REQ-016 In IDLE, when count < DEPTH and redirect=0, the FSM SHALL go to REQ next cycle.
REQ-017 In REQ and DROP, imem_req SHALL be 1; in IDLE it SHALL be 0.
REQ-018 imem_addr SHALL equal fetch_pc in REQ and stay stable until imem_ack.
REQ-019 At most one request SHALL be outstanding at any time.
REQ-020 Zero-wait ack (ack in the first REQ cycle) SHALL be accepted.
REQ-021 On imem_ack in REQ without redirect, the FIFO SHALL push {fetch_pc, imem_rdata} and fetch_pc SHALL advance by 4.
REQ-022 fetch_pc arithmetic SHALL wrap modulo 2^64.
REQ-023 After the ack, the FSM SHALL stay in REQ when count_after_push < DEPTH, else go to IDLE.
REQ-024 out_valid SHALL equal (count != 0); out_instr and out_pc SHALL show the head entry.
REQ-025 A pop SHALL occur when out_valid && out_ready.
REQ-026 A push and pop in the same cycle SHALL leave count unchanged and preserve order.
REQ-027 No push SHALL occur when full; REQ-016 guarantees this.
REQ-028 On redirect=1, the block SHALL, on the next edge:
- clear the FIFO (count=0);
- set fetch_pc = {redirect_pc[63:2], 2'b00};
- ignore any same-cycle pop.
REQ-029 Redirect in REQ without same-cycle ack: FSM SHALL go to DROP.
- imem_req and the old imem_addr stay held until ack.
- The acked data is discarded.
- The FSM then goes to REQ, using the new fetch_pc.
REQ-030 Redirect coinciding with imem_ack in REQ: the returned word SHALL be discarded, and the FSM SHALL go to REQ.
REQ-031 Redirect in DROP SHALL update fetch_pc only and remain in DROP unless ack arrives the same cycle; in that case the FSM goes to REQ.
REQ-032 Redirect in IDLE SHALL update fetch_pc, clear the FIFO, and go to REQ.
REQ-033 Back-to-back redirects SHALL each take effect; the last one wins.
REQ-034 The FIFO read/write pointers SHALL wrap modulo DEPTH.

Reset
REQ-035 While rst=1, on each edge the block SHALL set:
- fetch_pc=RESET_PC, count=0, FSM=IDLE;
- outputs imem_req=0, out_valid=0.
REQ-036 rst SHALL take priority over redirect and imem_ack.
REQ-037 An in-flight request at reset SHALL be abandoned; any later stray ack in IDLE SHALL be ignored.
REQ-038 The first request SHALL issue with imem_addr=RESET_PC in the second cycle after rst deasserts.
REQ-039 out_instr/out_pc values SHALL be don't-care while out_valid=0.

Verification
REQ-040 Streaming test:
- Setup: RESET_PC=0, zero-wait ack, out_ready=1, rdata = address-derived.
- Required: out_pc = 0, 4, 8, ... with one instruction per cycle once primed, and matching out_instr.
REQ-041 Backpressure test:
- Stimulus: out_ready=0.
- Required: exactly DEPTH entries pushed (pc 0, 4); imem_req drops to 0.
- After out_ready=1: order preserved and fetching resumes at pc 8.
REQ-042 Redirect during wait:
- Stimulus: request to 0x10 pending 3 cycles; redirect to 0x200 in cycle 1.
- Required: the 0x10 data is never output; the next imem_addr=0x200; first out_pc=0x200.
REQ-043 Redirect with simultaneous ack and pop:
- Required: FIFO empties; the ack data is dropped; next out_pc=redirect target.
- Also: redirect_pc=0x203 yields imem_addr=0x200.
REQ-044 Wrap test: redirect_pc=64'hFFFF_FFFF_FFFF_FFFC; required: out_pc sequence FFFC then 0x0.
REQ-045 Reset mid-request: rst while waiting on an ack; required:
- The late ack is ignored.
- Post-reset out_pc starts at RESET_PC.
